uart_rx_core: RTL and testbench

//   UART receiver, 8N1, LSB first: the receive end of the link served by the UartTX transmitter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_core_if.sv | 13 +
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_core.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
// Used by both the receive core and the transmitter side.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    function automatic int calc_div(input int clk_freq, input int rate);
        return clk_freq / rate;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side output bundle: delivered byte plus its status strobes.
interface uart_rx_core_if
    import uart_pkg::*;
;
    logic [DATA_BITS-1:0] dataOUT;
    logic                 validOUT;
    logic                 frameErrOUT;
    logic                 parityErrOUT;
    logic                 nBusyOUT;

    modport master (output dataOUT, validOUT, frameErrOUT, parityErrOUT, nBusyOUT);
    modport slave  (input  dataOUT, validOUT, frameErrOUT, parityErrOUT, nBusyOUT);
endinterface

// File: rtl/uart_baud_tick.sv
// Clearable tick divider: one-cycle tick every CLK_FREQ/RATE clocks, restartable via clr.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 48_000_000,
    parameter int RATE     = 153_600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, RATE);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: divider below 2, clock too slow for requested rate");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with oversampled mid-bit sampling and framing-error detection.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 48_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clkIN,
    input  logic nResetIN,
    input  logic rxIN,
    uart_rx_core_if.master rx_if
);
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_state_e          state_q, state_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, nbusy_q, nbusy_d;
    logic                 tick, tick_clr, at_mid;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, perr_q, perr_d;
`endif

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .RATE(BAUD_RATE * OVERSAMPLE)) u_tick (
        .clk   (clkIN),
        .rst_n (nResetIN),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Start bit is judged half a bit in; every later bit one full bit after that.
    assign at_mid = tick && (sc_q == ((state_q == ST_START) ? SC_MID : SC_LAST));

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        nbusy_d  = nbusy_q;
        tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (tick && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
            sc_d = at_mid ? '0 : sc_q + SC_W'(1);

        case (state_q)
            ST_IDLE: if (!rx_s_q) begin
                state_d  = ST_START;
                nbusy_d  = 1'b0;
                sc_d     = '0;
                tick_clr = 1'b1;
            end
            ST_START: if (at_mid) begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                    nbusy_d = 1'b1;
                end else begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: if (at_mid) begin
                shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (at_mid) begin
                par_bad_d = (^shift_q) ^ rx_s_q;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: if (at_mid) begin
                if (rx_s_q) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    nbusy_d = 1'b1;
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_bad_q;
`endif
                end else begin
                    ferr_d  = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            // Line held low: stay here until it idles so no phantom bytes appear.
            ST_BREAK: if (rx_s_q) begin
                state_d = ST_IDLE;
                nbusy_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                nbusy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            sc_q      <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            nbusy_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rxIN;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            sc_q      <= sc_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            nbusy_q   <= nbusy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_if.dataOUT     = data_q;
    assign rx_if.validOUT    = valid_q;
    assign rx_if.frameErrOUT = ferr_q;
    assign rx_if.nBusyOUT    = nbusy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parityErrOUT = perr_q;
`else
    assign rx_if.parityErrOUT = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames driven in real time, strobes scored against a frame-level queue model.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int  CLK_FREQ = 3_200_000;
    localparam int  BAUD     = 100_000;
    localparam int  OS       = 16;
    localparam real CLK_NS   = 10.0;
    localparam real BIT_NS   = 320.0;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic clkIN = 1'b0;
    logic nResetIN = 1'b0;
    logic rxIN = 1'b1;

    always #5 clkIN = ~clkIN;

    uart_rx_core_if u_if ();

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .clkIN    (clkIN),
        .nResetIN (nResetIN),
        .rxIN     (rxIN),
        .rx_if    (u_if)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_valid = 0;
    logic [7:0] last_good = 8'h00;
    real        t_start = 0.0;
    real        t_valid = 0.0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Model: each transmitted frame yields exactly one outcome, in order.
    task automatic push(input logic [7:0] b, input bit stop, input bit flip);
        exp_t e;
        e.ferr = !stop;
        e.data = b;
        e.perr = HAS_PAR && stop && flip;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input real bit_ns, input bit flip);
        rxIN = 1'b0;
        t_start = $realtime;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxIN = b[i];
            #(bit_ns);
        end
        if (HAS_PAR) begin
            rxIN = (^b) ^ flip;
            #(bit_ns);
        end
        rxIN = stop;
        #(bit_ns);
    endtask

    task automatic wait_done(input int max_clk, input string tag);
        int i;
        for (i = 0; i < max_clk; i++) begin
            @(negedge clkIN);
            if (exp_q.size() == 0 && u_if.nBusyOUT) break;
        end
        chk({tag, "_done"}, i < max_clk, 1);
    endtask

    always @(negedge clkIN) begin
        if (nResetIN) begin
            if (u_if.parityErrOUT && !u_if.validOUT) chk("perr_without_valid", 1'b1, 1'b0);
            if (u_if.validOUT || u_if.frameErrOUT) begin
                chk("strobe_exclusive", u_if.validOUT & u_if.frameErrOUT, 0);
                chk("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("kind_ferr", u_if.frameErrOUT, mon_e.ferr);
                    if (mon_e.ferr) begin
                        chk("data_hold", u_if.dataOUT, last_good);
                    end else begin
                        last_good = mon_e.data;
                        chk("data", u_if.dataOUT, mon_e.data);
                        chk("perr", u_if.parityErrOUT, mon_e.perr);
                    end
                end
                if (u_if.validOUT) begin
                    n_valid++;
                    t_valid = $realtime;
                end
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $realtime);
        $fatal(1, "watchdog");
    end

    initial begin
        real lat;
        int  seen;
        int  nv0;
        #20;
        chk("rst_data",  u_if.dataOUT, 8'h00);
        chk("rst_valid", u_if.validOUT, 0);
        chk("rst_ferr",  u_if.frameErrOUT, 0);
        chk("rst_perr",  u_if.parityErrOUT, 0);
        chk("rst_nbusy", u_if.nBusyOUT, 1);
        @(negedge clkIN);
        nResetIN = 1'b1;
        repeat (5) @(negedge clkIN);

        // 1: nominal frame and latency
        push(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, BIT_NS, 1'b0);
        wait_done(400, "t1");
        lat = (t_valid - t_start) / CLK_NS;
        chk("t1_latency_in_range", (lat >= 305.0) && (lat <= 309.0), 1);
        chk("t1_data", u_if.dataOUT, 8'h55);

        // 2: short glitch is rejected
        @(negedge clkIN);
        rxIN = 1'b0;
        repeat (4) @(negedge clkIN);
        rxIN = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (!u_if.nBusyOUT) seen = 1;
            else @(negedge clkIN);
        end
        chk("t2_busy_low", seen, 1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clkIN);
            if (u_if.nBusyOUT) seen = 1;
        end
        chk("t2_busy_back", seen, 1);
        #(BIT_NS * 2);

        // 3: bad stop, line held low, then recovery
        push(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, BIT_NS, 1'b0);
        rxIN = 1'b0;
        #(BIT_NS * 3);
        chk("t3_busy_in_break", u_if.nBusyOUT, 0);
        chk("t3_data_hold", u_if.dataOUT, 8'h55);
        rxIN = 1'b1;
        #(BIT_NS * 2);
        push(8'h0F, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, BIT_NS, 1'b0);
        wait_done(400, "t3");
        chk("t3_data", u_if.dataOUT, 8'h0F);

        // 4: back-to-back frames with transmitter 2 % fast
        nv0 = n_valid;
        push(8'h00, 1'b1, 1'b0);
        push(8'hFF, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, BIT_NS / 1.02, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_NS / 1.02, 1'b0);
        wait_done(400, "t4");
        chk("t4_valid_count", n_valid - nv0, 2);
        chk("t4_data", u_if.dataOUT, 8'hFF);

        // 5: reset during data bit 4 of 0x3C
        rxIN = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxIN = (i >= 2);
            #(BIT_NS);
        end
        rxIN = 1'b1;
        #(BIT_NS / 2);
        chk("t5_busy_before", u_if.nBusyOUT, 0);
        nResetIN = 1'b0;
        #1;
        last_good = 8'h00;
        chk("t5_data",  u_if.dataOUT, 8'h00);
        chk("t5_valid", u_if.validOUT, 0);
        chk("t5_ferr",  u_if.frameErrOUT, 0);
        chk("t5_perr",  u_if.parityErrOUT, 0);
        chk("t5_nbusy", u_if.nBusyOUT, 1);
        repeat (3) @(negedge clkIN);
        nResetIN = 1'b1;
        #(BIT_NS * 2);
        push(8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, BIT_NS, 1'b0);
        wait_done(400, "t5");
        chk("t5_data_after", u_if.dataOUT, 8'h81);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then parity bad
        push(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, BIT_NS, 1'b0);
        push(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, BIT_NS, 1'b1);
        wait_done(400, "t6");
`endif

        // Randomized frames: data, stop bit, +/-2 % baud, gaps
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            bit         stop;
            bit         flip;
            real        bn;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            flip = 1'($urandom_range(0, 1));
            bn   = BIT_NS / (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            push(b, stop, flip);
            send_frame(b, stop, bn, flip);
            if (!stop) begin
                rxIN = 1'b0;
                #(bn * $urandom_range(0, 2));
                rxIN = 1'b1;
                #(bn * (1 + $urandom_range(0, 1)));
            end else begin
                #(bn * $urandom_range(0, 2));
            end
        end
        wait_done(600, "rand");
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
